// File: rtl/ifu_prefetch.sv
// Instruction prefetch unit: credit-limited in-order fetch requests, response
// buffering with addresses, redirect flush with stale-response dropping.
module ifu_prefetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  output logic        req_valid_o,
  output logic [31:0] req_addr_o,
  input  logic        req_ready_i,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic        inst_valid_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  logic [31:0]      fetch_pc_reg, fetch_pc_next;
  logic [31:0]      rsp_pc_reg, rsp_pc_next;
  logic [CNT_W-1:0] fifo_count_reg, fifo_count_next;
  logic [CNT_W-1:0] outstanding_reg, outstanding_next;
  logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;

  logic [31:0] slot_pc   [FIFO_DEPTH];
  logic [31:0] slot_inst [FIFO_DEPTH];

  logic [31:0]  jump_target;
  logic [CNT_W:0] credit_used;
  logic         req_fire;
  logic         rsp_take;
  logic         push;
  logic         pop;

  assign jump_target = {jump_addr_i[31:2], 2'b00};
  assign credit_used = {1'b0, outstanding_reg} + {1'b0, fifo_count_reg};

  // Credits cover both in-flight requests and buffered entries, so every
  // response is guaranteed a free slot.
  assign req_valid_o = !rst && !jump_en_i && (credit_used < DEPTH_LIMIT);
  assign req_addr_o  = fetch_pc_reg;
  assign req_fire    = req_valid_o && req_ready_i;

  assign rsp_take     = rsp_valid_i && !rst;
  assign push         = rsp_take && !jump_en_i && (drop_cnt_reg == '0);
  assign inst_valid_o = !rst && (fifo_count_reg != '0);
  assign pop          = inst_valid_o && !hold_flag_i && !jump_en_i;

  // Head is read combinationally so a response is visible the following cycle.
  assign inst_o      = inst_valid_o ? slot_inst[rd_ptr_reg] : NOP_INST;
  assign inst_addr_o = inst_valid_o ? slot_pc[rd_ptr_reg]   : 32'h0;

  always_comb begin
    fetch_pc_next    = fetch_pc_reg;
    rsp_pc_next      = rsp_pc_reg;
    fifo_count_next  = fifo_count_reg;
    outstanding_next = outstanding_reg;
    drop_cnt_next    = drop_cnt_reg;
    wr_ptr_next      = wr_ptr_reg;
    rd_ptr_next      = rd_ptr_reg;

    if (jump_en_i) begin
      // Every request still in flight after this cycle belongs to the old path.
      fetch_pc_next    = jump_target;
      rsp_pc_next      = jump_target;
      fifo_count_next  = '0;
      wr_ptr_next      = '0;
      rd_ptr_next      = '0;
      drop_cnt_next    = outstanding_reg - CNT_W'(rsp_take);
      outstanding_next = outstanding_reg - CNT_W'(rsp_take);
    end else begin
      if (req_fire) begin
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      outstanding_next = outstanding_reg + CNT_W'(req_fire) - CNT_W'(rsp_take);
      if (rsp_take && (drop_cnt_reg != '0)) begin
        drop_cnt_next = drop_cnt_reg - CNT_W'(1);
      end
      if (push) begin
        rsp_pc_next = rsp_pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      fifo_count_next = fifo_count_reg + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_reg    <= RESET_ADDR;
      rsp_pc_reg      <= RESET_ADDR;
      fifo_count_reg  <= '0;
      outstanding_reg <= '0;
      drop_cnt_reg    <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
    end else begin
      fetch_pc_reg    <= fetch_pc_next;
      rsp_pc_reg      <= rsp_pc_next;
      fifo_count_reg  <= fifo_count_next;
      outstanding_reg <= outstanding_next;
      drop_cnt_reg    <= drop_cnt_next;
      wr_ptr_reg      <= wr_ptr_next;
      rd_ptr_reg      <= rd_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PTR_W'(gi))) begin
          slot_pc[gi]   <= rsp_pc_reg;
          slot_inst[gi] <= rsp_data_i;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_ifu_prefetch.sv
// Bench for ifu_prefetch: fixed-latency in-order memory model, scoreboard of
// expected instruction addresses, per-cycle request-address and idle-output checks.
module tb_ifu_prefetch;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        req_valid_o;
  logic [31:0] req_addr_o;
  logic        req_ready_i;
  logic        rsp_valid_i;
  logic [31:0] rsp_data_i;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;

  always #5 clk = ~clk;

  ifu_prefetch #(.RESET_ADDR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i), .hold_flag_i(hold_flag_i),
    .req_valid_o(req_valid_o), .req_addr_o(req_addr_o), .req_ready_i(req_ready_i),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i),
    .inst_o(inst_o), .inst_addr_o(inst_addr_o), .inst_valid_o(inst_valid_o)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;
  int pops  = 0;
  mreq_t       mem_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;
  logic [31:0] exp_req_pc;

  // Bench-side stimulus, applied at each negedge by step().
  logic        drv_rst  = 1'b1;
  logic        drv_jmp  = 1'b0;
  logic [31:0] drv_jadr = 32'h0;
  logic        drv_hold = 1'b0;
  logic        drv_rdy  = 1'b1;

  logic [31:0] h_addr, h_inst;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    rst         = drv_rst;
    jump_en_i   = drv_jmp;
    jump_addr_i = drv_jadr;
    hold_flag_i = drv_hold;
    req_ready_i = drv_rdy;
    if (drv_rst) begin
      mem_q.delete();
      rsp_valid_i = 1'b1;            // junk response that must be ignored
      rsp_data_i  = 32'hDEAD_BEEF;
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp_valid_i = 1'b1;
      rsp_data_i  = memf(mem_q[0].addr);
    end else begin
      rsp_valid_i = 1'b0;
      rsp_data_i  = 32'h0;
    end
    #1;
    if (drv_rst) begin
      chk("rst_req_valid", 32'(req_valid_o), 32'd0);
      chk("rst_inst_valid", 32'(inst_valid_o), 32'd0);
      chk("rst_inst", inst_o, NOP);
      chk("rst_inst_addr", inst_addr_o, 32'h0);
      exp_q.delete();
      gen_pc     = 32'h0;
      exp_req_pc = 32'h0;
    end else begin
      if (drv_jmp) chk("jump_no_req", 32'(req_valid_o), 32'd0);
      if (req_valid_o) chk("req_addr", req_addr_o, exp_req_pc);
      if (req_valid_o && req_ready_i) begin
        mem_q.push_back('{addr: req_addr_o, due: cyc + lat});
        exp_req_pc += 32'd4;
      end
      if (rsp_valid_i) void'(mem_q.pop_front());
      if (!inst_valid_o) begin
        chk("idle_inst", inst_o, NOP);
        chk("idle_addr", inst_addr_o, 32'h0);
      end else if (!drv_hold && !drv_jmp) begin
        chk("pop_addr", inst_addr_o, exp_q[0]);
        chk("pop_inst", inst_o, memf(exp_q[0]));
        $display("pop  cyc=%0d addr=%h inst=%h", cyc, inst_addr_o, inst_o);
        void'(exp_q.pop_front());
        pops++;
      end
      if (drv_jmp) begin
        exp_q.delete();
        gen_pc     = {drv_jadr[31:2], 2'b00};
        exp_req_pc = gen_pc;
      end
    end
    while (exp_q.size() < 8) begin
      exp_q.push_back(gen_pc);
      gen_pc += 32'd4;
    end
    cyc++;
  endtask

  task automatic run_pops(input string tag, input int n, input int budget);
    int target;
    int k;
    target = pops + n;
    k = 0;
    while (pops < target && k < budget) begin
      step();
      k++;
    end
    chk(tag, 32'(pops), 32'(target));
  endtask

  task automatic jump_to(input logic [31:0] a);
    drv_jmp  = 1'b1;
    drv_jadr = a;
    step();
    drv_jmp  = 1'b0;
  endtask

  initial begin
    rst = 1'b1; jump_en_i = 1'b0; jump_addr_i = 32'h0; hold_flag_i = 1'b0;
    req_ready_i = 1'b1; rsp_valid_i = 1'b0; rsp_data_i = 32'h0;

    // 1: reset then first fetch
    repeat (3) step();
    drv_rst = 1'b0;
    step();
    chk("t1_req_valid", 32'(req_valid_o), 32'd1);
    chk("t1_req_addr", req_addr_o, 32'h0);
    chk("t1_inst_valid", 32'(inst_valid_o), 32'd0);
    chk("t1_inst", inst_o, NOP);
    step();
    step();
    chk("t1_first_addr", inst_addr_o, 32'h0);

    // 2: back-to-back stream, no gaps
    for (int i = 0; i < 7; i++) begin
      step();
      chk("t2_no_gap", 32'(inst_valid_o), 32'd1);
    end

    // 3: hold for 4 cycles
    drv_hold = 1'b1;
    step();
    chk("t3_valid", 32'(inst_valid_o), 32'd1);
    h_addr = inst_addr_o;
    h_inst = inst_o;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t3_hold_addr", inst_addr_o, h_addr);
      chk("t3_hold_inst", inst_o, h_inst);
    end
    chk("t3_credit_out", 32'(req_valid_o), 32'd0);
    drv_hold = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step();
      chk("t3_resume", 32'(inst_valid_o), 32'd1);
    end

    // 5: memory not ready for 5 cycles
    drv_rdy = 1'b0;
    step();
    h_addr = req_addr_o;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_addr_held", req_addr_o, h_addr);
    end
    drv_rdy = 1'b1;
    run_pops("t5_drain", 6, 40);

    // 4: 3-cycle memory, redirect with requests in flight
    lat = 3;
    repeat (8) step();
    jump_to(32'h0000_0100);
    step();
    chk("t4_flushed", 32'(inst_valid_o), 32'd0);
    run_pops("t4_after_jump", 6, 60);

    // 6: redirect and hold together while the FIFO is full
    lat = 1;
    drv_hold = 1'b1;
    repeat (10) step();
    chk("t6_full_valid", 32'(inst_valid_o), 32'd1);
    chk("t6_full_noreq", 32'(req_valid_o), 32'd0);
    jump_to(32'h0000_0201);
    step();
    chk("t6_flushed", 32'(inst_valid_o), 32'd0);
    drv_hold = 1'b0;
    run_pops("t6_after_jump", 5, 40);

    // PC wrap across 2^32
    jump_to(32'hFFFF_FFF8);
    run_pops("wrap", 5, 40);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
